// File: rtl/fft_addr_sequencer.sv
// ============================================================================
// fft_addr_sequencer
// Read/write address sequencer for an in-place radix-2 FFT with ping-pong,
// two-bank sample memories and a twiddle ROM.
// Rev 1.0
// ============================================================================
`default_nettype none

module fft_addr_sequencer #(
    parameter int LOG2N_MAX = 10,
    parameter int BFLY_LAT  = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [3:0]                i_log2n,
    input  logic                      i_stall,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_result_in_mem2,
    output logic [4:0][LOG2N_MAX-2:0] o_rd_addr,
    output logic [4:0]                o_rd_en,
    output logic [3:0][LOG2N_MAX-2:0] o_wr_addr,
    output logic [3:0]                o_wr_en,
    output logic                      o_top_even,
    output logic                      o_even_segment
);

    localparam int c_AW  = LOG2N_MAX - 1;
    localparam int c_DW  = $clog2(BFLY_LAT + 1);
    localparam int c_DLW = c_AW + 1 + 4;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(BFLY_LAT - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [3:0]      r_n;
    logic [3:0]      r_s;
    logic [c_AW-1:0] r_p;
    logic [c_DW-1:0] r_drain;
    logic            r_res_mem2;
    logic [c_DLW-1:0] r_dly [BFLY_LAT];

    logic            w_adv;
    logic            w_legal;
    logic            w_accept;
    logic            w_rd_valid;
    logic [3:0]      w_n_m1;
    logic [3:0]      w_sh;
    logic [3:0]      w_sh2;
    logic [c_AW-1:0] w_mask;
    logic [c_AW-1:0] w_dif;
    logic [c_AW-1:0] w_seg;
    logic [c_AW-1:0] w_tw;
    logic [c_AW-1:0] w_b;
    logic            w_even_seg;
    logic            w_top_even;
    logic            w_p_last;
    logic            w_last_stage;
    logic            w_drain_last;
    logic [c_DLW-1:0] w_dly_in;
    logic [c_DLW-1:0] w_dly_out;
    logic [c_AW-1:0] w_dly_addr;
    logic            w_dly_top;
    logic [3:0]      w_dly_en;

    assign w_adv        = !i_stall;
    assign w_legal      = (i_log2n >= 4'd2) && (i_log2n <= 4'(LOG2N_MAX));
    assign w_accept     = (r_state == c_S_IDLE) && w_adv && i_start && w_legal;
    assign w_rd_valid   = (r_state == c_S_RUN) && w_adv;
    assign w_n_m1       = r_n - 4'd1;
    assign w_sh         = w_n_m1 - r_s;
    assign w_sh2        = w_sh - 4'd1;
    assign w_mask       = (c_AW'(1) << w_n_m1) - c_AW'(1);
    // At stage 0 the shift can exceed the field; the resulting 0 equals P mod P.
    assign w_dif        = c_AW'(1) << w_sh;
    assign w_seg        = r_p >> w_sh;
    assign w_even_seg   = ~w_seg[0];
    assign w_b          = w_even_seg ? ((r_p + w_dif) & w_mask) : ((r_p - w_dif) & w_mask);
    assign w_last_stage = (r_s == w_n_m1);
    assign w_top_even   = w_last_stage ? 1'b1 : ~|(r_p & (c_AW'(1) << w_sh2));
    assign w_p_last     = (r_p == w_mask);
    assign w_drain_last = (r_drain == c_DRAIN_LAST);

    always_comb begin
        w_tw = '0;
        for (int i = 0; i < c_AW; i++) begin
            w_tw[i] = w_seg[c_AW-1-i];
        end
    end

    // Delay-line entry: {pair index, top_even, write enables}; idle slots carry zeros.
    always_comb begin
        w_dly_in = '0;
        if (w_rd_valid) begin
            w_dly_in = {r_p, w_top_even, (r_s[0] ? 4'b0011 : 4'b1100)};
        end
    end

    assign w_dly_out  = r_dly[BFLY_LAT-1];
    assign w_dly_addr = w_dly_out[c_DLW-1 -: c_AW];
    assign w_dly_top  = w_dly_out[4];
    assign w_dly_en   = w_dly_out[3:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_adv) begin
            case (r_state)
                c_S_IDLE:  if (w_accept) w_state_nxt = c_S_RUN;
                c_S_RUN:   if (w_p_last) w_state_nxt = c_S_DRAIN;
                c_S_DRAIN: if (w_drain_last) w_state_nxt = w_last_stage ? c_S_DONE : c_S_RUN;
                default:   w_state_nxt = c_S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_n        <= '0;
            r_s        <= '0;
            r_p        <= '0;
            r_drain    <= '0;
            r_res_mem2 <= 1'b0;
            for (int i = 0; i < BFLY_LAT; i++) begin
                r_dly[i] <= '0;
            end
        end else if (w_adv) begin
            r_dly[0] <= w_dly_in;
            for (int i = 1; i < BFLY_LAT; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_n        <= i_log2n;
                        r_s        <= '0;
                        r_p        <= '0;
                        r_drain    <= '0;
                        // Odd n means an even final stage index, which writes mem2.
                        r_res_mem2 <= i_log2n[0];
                    end
                end
                c_S_RUN: begin
                    r_drain <= '0;
                    r_p     <= w_p_last ? '0 : r_p + c_AW'(1);
                end
                c_S_DRAIN: begin
                    if (w_drain_last) begin
                        r_drain <= '0;
                        if (!w_last_stage) begin
                            r_s <= r_s + 4'd1;
                            r_p <= '0;
                        end
                    end else begin
                        r_drain <= r_drain + c_DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_busy           = (r_state != c_S_IDLE);
        o_done           = (r_state == c_S_DONE) && w_adv;
        o_result_in_mem2 = r_res_mem2;
        o_rd_en          = '0;
        o_rd_addr        = '0;
        o_even_segment   = 1'b0;
        if (w_rd_valid) begin
            o_rd_en        = r_s[0] ? 5'b11001 : 5'b00111;
            o_even_segment = w_even_seg;
            o_rd_addr[0]   = w_tw;
            if (r_s[0]) begin
                o_rd_addr[3] = r_p;
                o_rd_addr[4] = w_b;
            end else begin
                o_rd_addr[1] = r_p;
                o_rd_addr[2] = w_b;
            end
        end
        o_wr_en    = '0;
        o_wr_addr  = '0;
        o_top_even = 1'b0;
        if (w_adv) begin
            o_wr_en    = w_dly_en;
            o_top_even = w_dly_top;
            for (int i = 0; i < 4; i++) begin
                o_wr_addr[i] = w_dly_en[i] ? w_dly_addr : '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fft_addr_sequencer.sv
// ============================================================================
// tb_fft_addr_sequencer
// Scoreboard bench: expected read/write events queued at start, popped by a
// monitor whenever the sequencer presents an enable.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fft_addr_sequencer;

    localparam int LOG2N_MAX = 10;
    localparam int BFLY_LAT  = 3;
    localparam int AW        = LOG2N_MAX - 1;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                stall = 1'b0;
    logic [3:0]          log2n = 4'd0;
    logic                o_busy, o_done, o_result_in_mem2, o_top_even, o_even_segment;
    logic [4:0][AW-1:0]  o_rd_addr;
    logic [4:0]          o_rd_en;
    logic [3:0][AW-1:0]  o_wr_addr;
    logic [3:0]          o_wr_en;

    fft_addr_sequencer #(.LOG2N_MAX(LOG2N_MAX), .BFLY_LAT(BFLY_LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_log2n(log2n), .i_stall(stall),
        .o_busy(o_busy), .o_done(o_done), .o_result_in_mem2(o_result_in_mem2),
        .o_rd_addr(o_rd_addr), .o_rd_en(o_rd_en), .o_wr_addr(o_wr_addr), .o_wr_en(o_wr_en),
        .o_top_even(o_top_even), .o_even_segment(o_even_segment)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [4:0] en; logic [4:0][AW-1:0] addr; logic eseg; } rd_t;
    typedef struct packed { logic [3:0] en; logic [3:0][AW-1:0] addr; logic top; } wr_t;

    rd_t q_rd[$];
    wr_t q_wr[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Hand-computed n=3 tables, indexed [stage][pair].
    int B3  [3][4] = '{'{0, 1, 2, 3}, '{2, 3, 0, 1}, '{1, 0, 3, 2}};
    int TW3 [3][4] = '{'{0, 0, 0, 0}, '{0, 0, 256, 256}, '{0, 256, 128, 384}};
    int ES3 [3][4] = '{'{1, 1, 1, 1}, '{1, 1, 0, 0}, '{1, 0, 1, 0}};
    int TOP3[3][4] = '{'{1, 1, 0, 0}, '{1, 0, 1, 0}, '{1, 1, 1, 1}};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
        return r;
    endfunction

    function automatic rd_t mk_rd(input int s, input int p, input int b, input int tw, input int es);
        rd_t r;
        r = '0;
        r.eseg    = (es != 0);
        r.addr[0] = AW'(tw);
        if (s % 2 == 1) begin
            r.en = 5'b11001; r.addr[3] = AW'(p); r.addr[4] = AW'(b);
        end else begin
            r.en = 5'b00111; r.addr[1] = AW'(p); r.addr[2] = AW'(b);
        end
        return r;
    endfunction

    function automatic wr_t mk_wr(input int s, input int p, input int top);
        wr_t w;
        w = '0;
        w.top = (top != 0);
        if (s % 2 == 1) begin
            w.en = 4'b0011; w.addr[0] = AW'(p); w.addr[1] = AW'(p);
        end else begin
            w.en = 4'b1100; w.addr[2] = AW'(p); w.addr[3] = AW'(p);
        end
        return w;
    endfunction

    // Pair p at stage s touches p and its partner p^2^(n-1-s); stage 0 partners share an address.
    task automatic push_run(input int n);
        int np, k, b, tw, es, top;
        np = 1 << (n - 1);
        for (int s = 0; s < n; s++) begin
            for (int p = 0; p < np; p++) begin
                if (n == 3) begin
                    b = B3[s][p]; tw = TW3[s][p]; es = ES3[s][p]; top = TOP3[s][p];
                end else begin
                    k   = n - 1 - s;
                    b   = (s == 0) ? p : (p ^ (1 << k));
                    es  = (s == 0) ? 1 : ((((p >> k) & 1) == 0) ? 1 : 0);
                    tw  = int'(bitrev(AW'(p >> k)));
                    top = (s == n - 1) ? 1 : ((((p >> (n - 2 - s)) & 1) == 0) ? 1 : 0);
                end
                q_rd.push_back(mk_rd(s, p, b, tw, es));
                q_wr.push_back(mk_wr(s, p, top));
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        rd_t a_rd;
        wr_t a_wr;
        a_rd.en = o_rd_en; a_rd.addr = o_rd_addr; a_rd.eseg = o_even_segment;
        a_wr.en = o_wr_en; a_wr.addr = o_wr_addr; a_wr.top = o_top_even;
        if (o_rd_en != 5'd0) begin
            if (q_rd.size() == 0) check("rd_unexpected", 64'(0), 64'(1));
            else check("rd_seq", 64'(a_rd), 64'(q_rd.pop_front()));
        end else begin
            check("rd_idle_zero", 64'(a_rd), 64'(0));
        end
        if (o_wr_en != 4'd0) begin
            if (q_wr.size() == 0) check("wr_unexpected", 64'(0), 64'(1));
            else check("wr_seq", 64'(a_wr), 64'(q_wr.pop_front()));
        end else begin
            check("wr_idle_zero", 64'(a_wr), 64'(0));
        end
        if (stall) check("stall_no_enables", 64'({o_rd_en, o_wr_en}), 64'(0));
    end

    task automatic do_run(input int n, input int exp_done, input bit exp_res,
                          input int sa, input int sal, input int sb, input int sbl,
                          input int spulse);
        int cyc, busy_cnt, done_cyc;
        bit got, res;
        push_run(n);
        @(posedge clk); #1;
        log2n = 4'(n); start = 1'b1;
        cyc = 0; busy_cnt = 0; done_cyc = 0; got = 0; res = 0;
        while (!got && cyc < 6000) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == spulse);
            log2n = (cyc == spulse) ? 4'd2 : 4'(n);
            stall = (cyc >= sa && cyc < sa + sal) || (cyc >= sb && cyc < sb + sbl);
            @(negedge clk);
            if (o_busy) busy_cnt++;
            if (o_done) begin
                got = 1; done_cyc = cyc; res = o_result_in_mem2;
            end
        end
        stall = 1'b0; start = 1'b0;
        check($sformatf("done_cycle_n%0d", n), 64'(done_cyc), 64'(exp_done));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_done));
        check("result_in_mem2", 64'(res), 64'(exp_res));
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_after_done", 64'({o_busy, o_done}), 64'(0));
        check("rd_queue_empty", 64'(q_rd.size()), 64'(0));
        check("wr_queue_empty", 64'(q_wr.size()), 64'(0));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'({o_busy, o_done, o_result_in_mem2, o_rd_en, o_wr_en,
                                 o_top_even, o_even_segment, |o_rd_addr, |o_wr_addr}), 64'(0));
        rst_n = 1'b1;

        foreach (B3[i]) begin
            @(posedge clk); #1;
            log2n = (i == 0) ? 4'd1 : 4'd11; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            if (i < 2) check($sformatf("illegal_start_%0d", (i == 0) ? 1 : 11), 64'(o_busy), 64'(0));
        end

        // n=3 defaults, with a start pulse while busy that must be ignored.
        do_run(3, 22, 1'b1, 0, 0, 0, 0, 5);
        // 5 stalled cycles in stage-0 RUN, 2 in stage-0 DRAIN.
        do_run(3, 29, 1'b1, 2, 5, 11, 2, 0);
        do_run(2, 11, 1'b0, 0, 0, 0, 0, 0);
        do_run(10, 5151, 1'b0, 0, 0, 0, 0, 0);

        // Abort mid-RUN with asynchronous reset.
        push_run(3);
        @(posedge clk); #1;
        log2n = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("busy_before_reset", 64'({o_busy, o_rd_en}), 64'({1'b1, 5'b00111}));
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({o_busy, o_done, o_result_in_mem2, o_rd_en, o_wr_en,
                                          o_top_even, o_even_segment, |o_rd_addr, |o_wr_addr}), 64'(0));
        q_rd.delete();
        q_wr.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("no_done_in_reset", 64'({o_done, o_busy}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_run(3, 22, 1'b1, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
